// File: rtl/opl_pkt_stats_pkg.sv
// Shared encodings and default widths for the output-port-lookup packet statistics stage.
package opl_pkt_stats_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam int INFLIGHT_LSB = 0;
    localparam int OCC_LSB      = 8;
    localparam int DBG_FIELD_W  = 8;

    localparam int DEF_DATA_W     = 256;
    localparam int DEF_USER_W     = 128;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_INFLIGHT_W = 8;

endpackage

// File: rtl/opl_axis_skid.sv
// Two-entry AXI4-Stream skid buffer: full throughput with a registered s_axis ready.
module opl_axis_skid
    import opl_pkt_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEEP_W = DEF_DATA_W / 8,
    parameter int USER_W = DEF_USER_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic [KEEP_W-1:0] i_s_tkeep,
    input  logic [USER_W-1:0] i_s_tuser,
    input  logic              i_s_tvalid,
    input  logic              i_s_tlast,
    output logic              o_s_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic [KEEP_W-1:0] o_m_tkeep,
    output logic [USER_W-1:0] o_m_tuser,
    output logic              o_m_tvalid,
    output logic              o_m_tlast,
    input  logic              i_m_tready,
    output logic [1:0]        o_occ
);

    localparam int PW = DATA_W + KEEP_W + USER_W + 1;

    occ_e            r_state;
    logic            r_tready;
    logic            r_tvalid;
    logic [PW-1:0]   r_out;
    logic [PW-1:0]   r_skid;
    logic [PW-1:0]   w_in;
    logic            w_acc;
    logic            w_dlv;

    assign w_in  = {i_s_tdata, i_s_tkeep, i_s_tuser, i_s_tlast};
    assign w_acc = i_s_tvalid && r_tready;
    assign w_dlv = r_tvalid && i_m_tready;

    // Ready/valid are updated alongside the state so both reflect the next occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= EMPTY;
            r_tready <= 1'b0;
            r_tvalid <= 1'b0;
            r_out    <= '0;
            r_skid   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_tready <= 1'b1;
                    if (w_acc) begin
                        r_out    <= w_in;
                        r_state  <= ONE;
                        r_tvalid <= 1'b1;
                    end
                end
                ONE: begin
                    case ({w_acc, w_dlv})
                        2'b10: begin
                            r_skid   <= w_in;
                            r_state  <= FULL;
                            r_tready <= 1'b0;
                        end
                        2'b01: begin
                            r_state  <= EMPTY;
                            r_tvalid <= 1'b0;
                        end
                        2'b11: r_out <= w_in;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (w_dlv) begin
                        r_out    <= r_skid;
                        r_state  <= ONE;
                        r_tready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= EMPTY;
                    r_tready <= 1'b1;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign {o_m_tdata, o_m_tkeep, o_m_tuser, o_m_tlast} = r_out;
    assign o_m_tvalid = r_tvalid;
    assign o_s_tready = r_tready;
    assign o_occ      = r_state;

endmodule

// File: rtl/opl_pkt_stats.sv
// In-line AXI4-Stream packet statistics stage with CPU counters, debug and flip registers.
// Define OPL_PKT_STATS_SAT_EN to make the packet counters saturate instead of wrapping.
module opl_pkt_stats
    import opl_pkt_stats_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_W,
    parameter int C_AXIS_TUSER_WIDTH = DEF_USER_W,
    parameter int CNT_WIDTH          = DEF_CNT_W,
    parameter int INFLIGHT_WIDTH     = DEF_INFLIGHT_W
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [CNT_WIDTH-1:0]            counterin_reg,
    input  logic                            counterin_reg_clear,
    output logic [CNT_WIDTH-1:0]            counterout_reg,
    input  logic                            counterout_reg_clear,
    input  logic [31:0]                     cpu2ip_flip_reg,
    output logic [31:0]                     ip2cpu_flip_reg,
    output logic [31:0]                     ip2cpu_debug_reg
);

    localparam logic [INFLIGHT_WIDTH-1:0] INF_MAX = '1;

    logic [1:0]                w_occ;
    logic                      w_in_evt;
    logic                      w_out_evt;
    logic [INFLIGHT_WIDTH-1:0] r_inflight;
    logic [31:0]               w_dbg;

    opl_axis_skid #(
        .DATA_W (C_AXIS_DATA_WIDTH),
        .KEEP_W (C_AXIS_DATA_WIDTH / 8),
        .USER_W (C_AXIS_TUSER_WIDTH)
    ) u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .i_s_tdata  (s_axis_tdata),
        .i_s_tkeep  (s_axis_tkeep),
        .i_s_tuser  (s_axis_tuser),
        .i_s_tvalid (s_axis_tvalid),
        .i_s_tlast  (s_axis_tlast),
        .o_s_tready (s_axis_tready),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tkeep  (m_axis_tkeep),
        .o_m_tuser  (m_axis_tuser),
        .o_m_tvalid (m_axis_tvalid),
        .o_m_tlast  (m_axis_tlast),
        .i_m_tready (m_axis_tready),
        .o_occ      (w_occ)
    );

    assign w_in_evt  = s_axis_tvalid && s_axis_tready && s_axis_tlast;
    assign w_out_evt = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // A clear coinciding with an event counts that event, so the result is 1.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic clr, input logic evt);
        if (clr)
            return evt ? CNT_WIDTH'(1) : '0;
        if (!evt)
            return cnt;
`ifdef OPL_PKT_STATS_SAT_EN
        if (&cnt)
            return cnt;
`endif
        return cnt + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        w_dbg = '0;
        w_dbg[OCC_LSB +: DBG_FIELD_W]      = DBG_FIELD_W'(w_occ);
        w_dbg[INFLIGHT_LSB +: DBG_FIELD_W] = DBG_FIELD_W'(r_inflight);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counterin_reg    <= '0;
            counterout_reg   <= '0;
            r_inflight       <= '0;
            ip2cpu_flip_reg  <= '0;
            ip2cpu_debug_reg <= '0;
        end else begin
            counterin_reg    <= cnt_next(counterin_reg, counterin_reg_clear, w_in_evt);
            counterout_reg   <= cnt_next(counterout_reg, counterout_reg_clear, w_out_evt);
            ip2cpu_flip_reg  <= ~cpu2ip_flip_reg;
            ip2cpu_debug_reg <= w_dbg;
            // Hitting either bound means the upstream protocol was violated; just hold.
            if (w_in_evt && !w_out_evt && r_inflight != INF_MAX)
                r_inflight <= r_inflight + INFLIGHT_WIDTH'(1);
            else if (w_out_evt && !w_in_evt && r_inflight != '0)
                r_inflight <= r_inflight - INFLIGHT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_opl_pkt_stats.sv
// Scoreboard bench for opl_pkt_stats: beats queued on accept, compared on delivery.
module tb_opl_pkt_stats;

    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int UW  = 16;
    localparam int CW  = 4;
    localparam int IW  = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] counterin_reg;
    logic          counterin_reg_clear = 1'b0;
    logic [CW-1:0] counterout_reg;
    logic          counterout_reg_clear = 1'b0;
    logic [31:0]   cpu2ip_flip_reg = '0;
    logic [31:0]   ip2cpu_flip_reg;
    logic [31:0]   ip2cpu_debug_reg;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_pass = 0;

`ifdef OPL_PKT_STATS_SAT_EN
    localparam logic [CW-1:0] EXP16 = 4'd15;
`else
    localparam logic [CW-1:0] EXP16 = 4'd0;
`endif

    opl_pkt_stats #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .CNT_WIDTH          (CW),
        .INFLIGHT_WIDTH     (IW)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tkeep         (s_axis_tkeep),
        .s_axis_tuser         (s_axis_tuser),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tkeep         (m_axis_tkeep),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .counterin_reg        (counterin_reg),
        .counterin_reg_clear  (counterin_reg_clear),
        .counterout_reg       (counterout_reg),
        .counterout_reg_clear (counterout_reg_clear),
        .cpu2ip_flip_reg      (cpu2ip_flip_reg),
        .ip2cpu_flip_reg      (ip2cpu_flip_reg),
        .ip2cpu_debug_reg     (ip2cpu_debug_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Inputs change at posedge+1, so the negedge view equals what the next edge samples.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                chk("sb_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, sb.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                             input logic l, input logic clr);
        int  n = 0;
        bit  ok = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = d[KW-1:0] | 8'h01;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        counterin_reg_clear = clr;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1;
                sb.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
            end
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        counterin_reg_clear = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cpu2ip_flip_reg = 32'hA5A5_0F0F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_cnt_in",   counterin_reg, 0);
        chk("rst_cnt_out",  counterout_reg, 0);
        chk("rst_flip",     ip2cpu_flip_reg, 0);
        chk("rst_debug",    ip2cpu_debug_reg, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);

        // Three single-beat packets, sink always ready.
        m_axis_tready = 1'b1;
        send_beat(64'h1111_0000_0000_0001, 16'h0A01, 1'b1, 1'b0);
        chk("lat_tvalid", m_axis_tvalid, 1);
        chk("lat_tdata",  m_axis_tdata, 64'h1111_0000_0000_0001);
        idle(1);
        chk("dbg_occ1_inf1", ip2cpu_debug_reg, 32'h0000_0101);
        send_beat(64'h2222_0000_0000_0002, 16'h0A02, 1'b1, 1'b0);
        send_beat(64'h3333_0000_0000_0003, 16'h0A03, 1'b1, 1'b0);
        idle(3);
        chk("t1_cnt_in",  counterin_reg, 3);
        chk("t1_cnt_out", counterout_reg, 3);
        chk("t1_debug",   ip2cpu_debug_reg, 0);

        // Four-beat packet against a stalled sink.
        m_axis_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_beat(64'hBEEF_0000_0000_0000 | 64'(i), 16'h0B00 + 16'(i), (i == 3), 1'b0);
            end
            begin
                idle(4);
                chk("t2_s_tready_low", s_axis_tready, 0);
                chk("t2_dbg_occ",      ip2cpu_debug_reg[15:8], 2);
                chk("t2_cnt_out_hold", counterout_reg, 3);
                chk("t2_cnt_in_hold",  counterin_reg, 3);
                m_axis_tready = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(m_axis_tvalid && m_axis_tlast) && n < 50);
                chk("t2_last_seen",      (n < 50), 1);
                chk("t2_cnt_out_before", counterout_reg, 3);
                @(posedge clk);
                #1;
                chk("t2_cnt_out_after", counterout_reg, 4);
            end
        join
        idle(3);
        chk("t2_cnt_in", counterin_reg, 4);
        chk("t2_debug",  ip2cpu_debug_reg, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // Clear pulses.
        send_beat(64'h5555_5555_5555_5555, 16'h0C05, 1'b1, 1'b0);
        idle(3);
        chk("t3_cnt_in5",  counterin_reg, 5);
        chk("t3_cnt_out5", counterout_reg, 5);
        send_beat(64'h6666_6666_6666_6666, 16'h0C06, 1'b1, 1'b1);
        chk("t3_clr_evt", counterin_reg, 1);
        idle(3);
        chk("t3_cnt_out6", counterout_reg, 6);
        counterin_reg_clear = 1'b1;
        idle(1);
        counterin_reg_clear = 1'b0;
        chk("t3_clr_only",     counterin_reg, 0);
        chk("t3_cnt_out_kept", counterout_reg, 6);
        counterout_reg_clear = 1'b1;
        idle(1);
        counterout_reg_clear = 1'b0;
        chk("t3_out_clr", counterout_reg, 0);
        chk("t3_in_kept", counterin_reg, 0);

        // Sixteen packets into 4-bit counters: wrap or saturate.
        for (int i = 0; i < 16; i++)
            send_beat({$urandom, $urandom}, 16'($urandom), 1'b1, 1'b0);
        idle(3);
        chk("t4_cnt_in16",  counterin_reg, EXP16);
        chk("t4_cnt_out16", counterout_reg, EXP16);

        // Flip register.
        cpu2ip_flip_reg = 32'h0000_FFFF;
        idle(1);
        chk("flip_a", ip2cpu_flip_reg, 32'hFFFF_0000);
        cpu2ip_flip_reg = 32'h1234_5678;
        idle(1);
        chk("flip_b", ip2cpu_flip_reg, 32'hEDCB_A987);

        // Reset during the second beat of a three-beat packet.
        send_beat(64'h7777_0000_0000_0000, 16'h0D00, 1'b0, 1'b0);
        s_axis_tdata  = 64'h7777_0000_0000_0001;
        s_axis_tvalid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_m_tvalid", m_axis_tvalid, 0);
        chk("mr_s_tready", s_axis_tready, 0);
        chk("mr_cnt_in",   counterin_reg, 0);
        chk("mr_cnt_out",  counterout_reg, 0);
        chk("mr_flip",     ip2cpu_flip_reg, 0);
        chk("mr_debug",    ip2cpu_debug_reg, 0);
        sb.delete();
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        send_beat(64'h8888_0000_0000_0008, 16'h0E08, 1'b1, 1'b0);
        idle(3);
        chk("mr_new_cnt_in",  counterin_reg, 1);
        chk("mr_new_cnt_out", counterout_reg, 1);
        chk("mr_new_debug",   ip2cpu_debug_reg, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
